// File: rtl/apb4_cmd_master_pkg.sv
// -----------------------------------------------------------------------------
// apb4_cmd_master_pkg
// Shared types and default widths for the APB4 command master.
//   state_t : requester FSM states (IDLE, SETUP, ACCESS, RESP)
//   cmd_t   : one command as presented on the command stream (default widths)
//   rsp_t   : one response as returned on the response stream (default widths)
//   cnt_width() : counter width needed to count 0 .. limit-1
// Optional feature macro used by the design: APB4_CMD_MASTER_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package apb4_cmd_master_pkg;

  localparam int unsigned ADDR_W_DEF      = 12;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned STRB_W_DEF      = DATA_W_DEF / 8;
  localparam int unsigned PROT_W          = 3;
  localparam int unsigned TIMEOUT_CYC_DEF = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [STRB_W_DEF-1:0] wstrb;
    logic [PROT_W-1:0]     prot;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  // Width of a counter that must reach limit-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    if (limit <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(limit);
    end
  endfunction

endpackage

// File: rtl/apb4_timeout_cnt.sv
// -----------------------------------------------------------------------------
// apb4_timeout_cnt
// Wait-state counter for the ACCESS phase. Cleared by i_clear, counts up on
// i_enable, saturates at LIMIT-1 and flags o_expire while sitting there.
//   clk, rst_b : clock, asynchronous active-low reset
//   i_clear    : restart the count at 0 (takes priority over i_enable)
//   i_enable   : count this cycle
//   o_expire   : count has reached LIMIT-1
// Instantiated only when APB4_CMD_MASTER_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module apb4_timeout_cnt
  import apb4_cmd_master_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CNT_W = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 32'd1);

  logic [CNT_W-1:0] r_cnt;

  assign o_expire = (r_cnt == CNT_LAST);

  // Wait-state count; saturates so a long stall cannot wrap past the limit.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_enable && !o_expire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/apb4_cmd_master.sv
// -----------------------------------------------------------------------------
// apb4_cmd_master
// Single-outstanding APB4 requester: turns a valid/ready command stream into
// APB4 SETUP/ACCESS transfers and returns read data / error status on a
// valid/ready response stream.
//   clk, rst_b          : clock, asynchronous active-low reset
//   i_cmd_*/o_cmd_ready : command stream (write, addr, wdata, wstrb, prot)
//   o_rsp_*/i_rsp_ready : response stream (rdata, err, timeout)
//   o_p*/i_p*           : APB4 requester bus
// Optional feature: define APB4_CMD_MASTER_TIMEOUT_EN to terminate an ACCESS
// phase after TIMEOUT_CYC cycles without PREADY (rsp_err=rsp_timeout=1).
// Every output except o_cmd_ready is a flop.
// -----------------------------------------------------------------------------
module apb4_cmd_master
  import apb4_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_write,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [DATA_W-1:0]   i_cmd_wdata,
  input  logic [DATA_W/8-1:0] i_cmd_wstrb,
  input  logic [PROT_W-1:0]   i_cmd_prot,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_rsp_err,
  output logic                o_rsp_timeout,
  output logic [ADDR_W-1:0]   o_paddr,
  output logic                o_psel,
  output logic                o_penable,
  output logic                o_pwrite,
  output logic [DATA_W-1:0]   o_pwdata,
  output logic [DATA_W/8-1:0] o_pstrb,
  output logic [PROT_W-1:0]   o_pprot,
  input  logic [DATA_W-1:0]   i_prdata,
  input  logic                i_pready,
  input  logic                i_pslverr
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_run;
  logic                w_accept;
  logic                w_expire;

  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic [PROT_W-1:0]   r_pprot;

  logic                r_psel;
  logic                r_penable;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic                w_psel_d;
  logic                w_penable_d;
  logic                w_rsp_valid_d;
  logic                w_rsp_load;
  logic [DATA_W-1:0]   w_rsp_rdata_d;
  logic                w_rsp_err_d;

  // r_run holds cmd_ready low while reset is asserted even though the state
  // register already reads IDLE; it rises on the first edge after release.
  assign o_cmd_ready = r_run && (r_state == IDLE);
  assign w_accept    = o_cmd_ready && i_cmd_valid;

  assign o_paddr     = r_paddr;
  assign o_pwrite    = r_pwrite;
  assign o_pwdata    = r_pwdata;
  assign o_pstrb     = r_pstrb;
  assign o_pprot     = r_pprot;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

`ifdef APB4_CMD_MASTER_TIMEOUT_EN
  logic w_cnt_clear;
  logic w_cnt_enable;
  logic r_rsp_timeout;

  // SETUP always precedes ACCESS, so clearing there means the count is 0 on
  // the first ACCESS cycle.
  assign w_cnt_clear  = (r_state == SETUP);
  assign w_cnt_enable = (r_state == ACCESS) && !i_pready;

  apb4_timeout_cnt #(
    .LIMIT    (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst_b    (rst_b),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_enable),
    .o_expire (w_expire)
  );

  // Timeout flag of the response; a completion with PREADY high is never a timeout.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_rsp_load) begin
      r_rsp_timeout <= !i_pready;
    end else begin
      r_rsp_timeout <= r_rsp_timeout;
    end
  end

  assign o_rsp_timeout = r_rsp_timeout;
`else
  // No timeout in this build: the tie-off evaluates to 0 for every legal
  // TIMEOUT_CYC (2..65535) and keeps the parameter referenced.
  localparam logic TIMEOUT_TIE = (TIMEOUT_CYC < 32'd2);

  assign w_expire      = 1'b0;
  assign o_rsp_timeout = TIMEOUT_TIE;
`endif

  // Run flag: 0 in reset, 1 from the first clock edge after release.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state decode; PREADY is checked before expiry so it wins on the
  // terminal cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SETUP;
        end else begin
          w_next_state = IDLE;
        end
      end
      SETUP: begin
        w_next_state = ACCESS;
      end
      ACCESS: begin
        if (i_pready) begin
          w_next_state = RESP;
        end else if (w_expire) begin
          w_next_state = RESP;
        end else begin
          w_next_state = ACCESS;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // FSM output decode: flop inputs derived from the next state so that the
  // registered outputs line up with the state they belong to.
  always_comb begin
    w_psel_d      = (w_next_state == SETUP) || (w_next_state == ACCESS);
    w_penable_d   = (w_next_state == ACCESS);
    w_rsp_valid_d = (w_next_state == RESP);
    w_rsp_load    = (r_state == ACCESS) && (w_next_state == RESP);
    if (i_pready && !r_pwrite) begin
      w_rsp_rdata_d = i_prdata;
    end else begin
      w_rsp_rdata_d = {DATA_W{1'b0}};
    end
    // Without PREADY the only way out of ACCESS is a timeout, which is an error.
    if (i_pready) begin
      w_rsp_err_d = i_pslverr;
    end else begin
      w_rsp_err_d = 1'b1;
    end
  end

  // Command latch; doubles as the APB address/data drivers, which therefore
  // hold their last values between transfers. Reads carry zero data/strobes.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_paddr  <= {ADDR_W{1'b0}};
      r_pwrite <= 1'b0;
      r_pwdata <= {DATA_W{1'b0}};
      r_pstrb  <= {STRB_W{1'b0}};
      r_pprot  <= {PROT_W{1'b0}};
    end else if (w_accept) begin
      r_paddr  <= i_cmd_addr;
      r_pwrite <= i_cmd_write;
      r_pwdata <= i_cmd_write ? i_cmd_wdata : {DATA_W{1'b0}};
      r_pstrb  <= i_cmd_write ? i_cmd_wstrb : {STRB_W{1'b0}};
      r_pprot  <= i_cmd_prot;
    end else begin
      r_paddr  <= r_paddr;
      r_pwrite <= r_pwrite;
      r_pwdata <= r_pwdata;
      r_pstrb  <= r_pstrb;
      r_pprot  <= r_pprot;
    end
  end

  // APB control and response registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      r_psel      <= w_psel_d;
      r_penable   <= w_penable_d;
      r_rsp_valid <= w_rsp_valid_d;
      if (w_rsp_load) begin
        r_rsp_rdata <= w_rsp_rdata_d;
        r_rsp_err   <= w_rsp_err_d;
      end else begin
        r_rsp_rdata <= r_rsp_rdata;
        r_rsp_err   <= r_rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_apb4_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb4_cmd_master
// Directed plus randomized transfers against a transaction-level model: each
// command predicts the APB view (address/data/strobes), the cycle-by-cycle
// phase sequence and the response. Build with APB4_CMD_MASTER_TIMEOUT_EN to
// exercise the timeout path (TIMEOUT_CYC=8).
// -----------------------------------------------------------------------------
module tb_apb4_cmd_master;
  import apb4_cmd_master_pkg::*;

  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned DW = DATA_W_DEF;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic [2:0]    cmd_prot = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  int checks = 0;
  int failures = 0;

  // Model of what the APB address/data lines should currently show.
  logic [AW-1:0] m_addr = '0;
  logic          m_write = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [SW-1:0] m_wstrb = '0;
  logic [2:0]    m_prot = '0;

  apb4_cmd_master #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYC   (TO)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_write   (cmd_write),
    .i_cmd_addr    (cmd_addr),
    .i_cmd_wdata   (cmd_wdata),
    .i_cmd_wstrb   (cmd_wstrb),
    .i_cmd_prot    (cmd_prot),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_err     (rsp_err),
    .o_rsp_timeout (rsp_timeout),
    .o_paddr       (paddr),
    .o_psel        (psel),
    .o_penable     (penable),
    .o_pwrite      (pwrite),
    .o_pwdata      (pwdata),
    .o_pstrb       (pstrb),
    .o_pprot       (pprot),
    .i_prdata      (prdata),
    .i_pready      (pready),
    .i_pslverr     (pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string ph, input logic e_psel, input logic e_pen,
                         input logic e_rv, input logic e_rdy);
    chk({ph, "_psel"},      64'(psel),      64'(e_psel));
    chk({ph, "_penable"},   64'(penable),   64'(e_pen));
    chk({ph, "_rsp_valid"}, 64'(rsp_valid), 64'(e_rv));
    chk({ph, "_cmd_ready"}, 64'(cmd_ready), 64'(e_rdy));
  endtask

  task automatic chk_bus(input string ph);
    chk({ph, "_paddr"},  64'(paddr),  64'(m_addr));
    chk({ph, "_pwrite"}, 64'(pwrite), 64'(m_write));
    chk({ph, "_pwdata"}, 64'(pwdata), 64'(m_wdata));
    chk({ph, "_pstrb"},  64'(pstrb),  64'(m_wstrb));
    chk({ph, "_pprot"},  64'(pprot),  64'(m_prot));
  endtask

  function automatic cmd_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] s, input logic [2:0] p);
    cmd_t c;
    c.write = w;
    c.addr  = a;
    c.wdata = d;
    c.wstrb = s;
    c.prot  = p;
    return c;
  endfunction

  // One complete transfer. waits = PREADY-low cycles in ACCESS before the
  // completing cycle; hold = RESP cycles with rsp_ready low. With send_next,
  // the command nc is presented while the response is being held.
  task automatic xfer(input cmd_t c, input int waits, input logic slverr,
                      input logic [DW-1:0] rd, input int hold,
                      input bit send_next, input cmd_t nc);
    bit   timed_out;
    int   acc_last;
    rsp_t e;
    timed_out = 1'b0;
`ifdef APB4_CMD_MASTER_TIMEOUT_EN
    timed_out = (waits >= int'(TO));
`endif
    acc_last  = timed_out ? int'(TO) - 1 : waits;
    e.rdata   = (timed_out || c.write) ? '0 : rd;
    e.err     = timed_out ? 1'b1 : slverr;
    e.timeout = timed_out;

    chk("idle_cmd_ready", 64'(cmd_ready), 64'(1'b1));
    cmd_valid = 1'b1;
    cmd_write = c.write;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    cmd_wstrb = c.wstrb;
    cmd_prot  = c.prot;
    tick();
    // Command accepted; scramble the stream to show the fields were latched.
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    cmd_wstrb = SW'($urandom);
    cmd_prot  = 3'($urandom);
    m_addr    = c.addr;
    m_write   = c.write;
    m_wdata   = c.write ? c.wdata : '0;
    m_wstrb   = c.write ? c.wstrb : '0;
    m_prot    = c.prot;

    chk_ctl("setup", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_bus("setup");
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
    tick();

    for (int i = 0; i <= acc_last; i++) begin
      chk_ctl("access", 1'b1, 1'b1, 1'b0, 1'b0);
      chk_bus("access");
      pready  = (i == waits);
      prdata  = (i == waits) ? rd : $urandom;
      pslverr = (i == waits) ? slverr : 1'($urandom);
      tick();
    end
    pready  = 1'b0;
    pslverr = 1'b0;

    for (int h = 0; h <= hold; h++) begin
      chk_ctl("resp", 1'b0, 1'b0, 1'b1, 1'b0);
      chk_bus("resp");
      chk("resp_rdata",   64'(rsp_rdata),   64'(e.rdata));
      chk("resp_err",     64'(rsp_err),     64'(e.err));
      chk("resp_timeout", 64'(rsp_timeout), 64'(e.timeout));
      if (send_next) begin
        cmd_valid = 1'b1;
        cmd_write = nc.write;
        cmd_addr  = nc.addr;
        cmd_wdata = nc.wdata;
        cmd_wstrb = nc.wstrb;
        cmd_prot  = nc.prot;
      end
      rsp_ready = (h == hold);
      tick();
    end
    rsp_ready = 1'b0;

    chk_ctl("done", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_bus("done");
  endtask

  initial begin
    cmd_t c;
    cmd_t n;
    n = mk(1'b0, '0, '0, '0, 3'd0);

    // Reset: every output low, including cmd_ready.
    #12;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_bus("reset");
    chk("reset_rsp_rdata",   64'(rsp_rdata),   64'(0));
    chk("reset_rsp_err",     64'(rsp_err),     64'(0));
    chk("reset_rsp_timeout", 64'(rsp_timeout), 64'(0));
    #1 rst_b = 1'b1;
    tick();
    chk("post_reset_ready", 64'(cmd_ready), 64'(1'b1));

    // Zero-wait write.
    xfer(mk(1'b1, 12'h004, 32'h0001_0001, 4'hF, 3'd0), 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, n);
    // Read with three wait states.
    xfer(mk(1'b0, 12'h000, 32'hFFFF_FFFF, 4'hF, 3'd2), 3, 1'b0, 32'h1234_5678, 0, 1'b0, n);
    // Read completing with PSLVERR.
    xfer(mk(1'b0, 12'h800, 32'h0, 4'h0, 3'd1), 1, 1'b1, 32'hA5A5_0F0F, 0, 1'b0, n);

    // Response held five cycles while a second command waits.
    c = mk(1'b1, 12'h010, 32'hCAFE_F00D, 4'h5, 3'd7);
    xfer(mk(1'b0, 12'h020, 32'h0, 4'h0, 3'd0), 0, 1'b0, 32'h0BAD_F00D, 5, 1'b1, c);
    xfer(c, 2, 1'b0, 32'h1111_2222, 0, 1'b0, n);

`ifdef APB4_CMD_MASTER_TIMEOUT_EN
    // PREADY never comes: forced termination after TO ACCESS cycles.
    xfer(mk(1'b0, 12'h044, 32'h0, 4'h0, 3'd0), 100, 1'b0, 32'h7777_7777, 1, 1'b0, n);
    // PREADY on the terminal cycle: normal completion.
    xfer(mk(1'b0, 12'h048, 32'h0, 4'h0, 3'd0), int'(TO) - 1, 1'b0, 32'h8888_9999, 0, 1'b0, n);
`else
    // Long stall: no timeout exists, the transfer completes normally.
    xfer(mk(1'b0, 12'h044, 32'h0, 4'h0, 3'd0), 20, 1'b0, 32'h7777_7777, 0, 1'b0, n);
`endif

    // Randomized transfers.
    for (int k = 0; k < 24; k++) begin
      c = mk(1'($urandom), AW'($urandom), $urandom, SW'($urandom), 3'($urandom));
      xfer(c, int'($urandom_range(0, 4)), 1'($urandom), $urandom,
           int'($urandom_range(0, 2)), 1'b0, n);
    end

    // Asynchronous reset during ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 12'h0AC;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre_rst_penable", 64'(penable), 64'(1'b1));
    #2 rst_b = 1'b0;
    #1;
    chk_ctl("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("async_rst_paddr", 64'(paddr), 64'(0));
    m_addr  = '0;
    m_write = 1'b0;
    m_wdata = '0;
    m_wstrb = '0;
    m_prot  = '0;
    #3 rst_b = 1'b1;
    tick();
    chk_ctl("rst_release", 1'b0, 1'b0, 1'b0, 1'b1);
    xfer(mk(1'b1, 12'h0FC, 32'h5555_AAAA, 4'h3, 3'd4), 1, 1'b0, 32'h0, 0, 1'b0, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
